// File: rtl/start_screen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : start_screen_pkg
// Brief   : Shared start-screen types and play-button geometry
// Revision: 1.0 - initial release
// ============================================================================
package start_screen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOVER = 2'd1,
        FIRED = 2'd2
    } state_t;

    // The renderer draws from these same values, so both sides stay aligned.
    localparam int PLAY_BTN_X = 380;
    localparam int PLAY_BTN_Y = 500;
    localparam int PLAY_BTN_W = 200;
    localparam int PLAY_BTN_H = 100;

endpackage
`default_nettype wire

// File: rtl/rect_hit.sv
`default_nettype none
// ============================================================================
// Module  : rect_hit
// Brief   : Combinational point-in-rectangle test for on-screen buttons
// Revision: 1.0 - initial release
// ============================================================================
module rect_hit #(
    parameter int RECT_X = 0,
    parameter int RECT_Y = 0,
    parameter int RECT_W = 1,
    parameter int RECT_H = 1
) (
    input  logic        valid,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    output logic        hit
);

    // One extra bit of headroom keeps the right/bottom edges from wrapping.
    localparam logic [11:0] c_x_lo = 12'(RECT_X);
    localparam logic [11:0] c_x_hi = 12'(RECT_X + RECT_W);
    localparam logic [11:0] c_y_lo = 12'(RECT_Y);
    localparam logic [11:0] c_y_hi = 12'(RECT_Y + RECT_H);

    logic [11:0] w_x;
    logic [11:0] w_y;

    assign w_x = {1'b0, x};
    assign w_y = {2'b00, y};

    assign hit = valid
              && (w_x >= c_x_lo) && (w_x < c_x_hi)
              && (w_y >= c_y_lo) && (w_y < c_y_hi);

endmodule
`default_nettype wire

// File: rtl/start_button_detector.sv
`default_nettype none
// ============================================================================
// Module  : start_button_detector
// Brief   : Dwell-to-press detector for the start-screen play button
// Revision: 1.0 - initial release
// ============================================================================
module start_button_detector
    import start_screen_pkg::*;
#(
    parameter int BTN_X        = PLAY_BTN_X,
    parameter int BTN_Y        = PLAY_BTN_Y,
    parameter int BTN_W        = PLAY_BTN_W,
    parameter int BTN_H        = PLAY_BTN_H,
    parameter int DWELL_FRAMES = 60,
    parameter int LOST_FRAMES  = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                enable_in,
    input  logic                                new_frame_in,
    input  logic                                cursor_valid_in,
    input  logic [10:0]                         cursor_x_in,
    input  logic [9:0]                          cursor_y_in,
    output logic                                hover_out,
    output logic [$clog2(DWELL_FRAMES+1)-1:0]   progress_out,
    output logic                                start_out
);

    localparam int PW = $clog2(DWELL_FRAMES + 1);
    localparam int MW = $clog2(LOST_FRAMES + 1);

    localparam logic [PW-1:0] c_dwell_one = PW'(1);
    localparam logic [PW-1:0] c_dwell_max = PW'(DWELL_FRAMES);
    localparam logic [MW-1:0] c_miss_max  = MW'(LOST_FRAMES);

    state_t        r_state, w_next_state;
    logic [PW-1:0] r_dwell, w_next_dwell, w_dwell_inc;
    logic [MW-1:0] r_miss,  w_next_miss,  w_miss_inc;
    logic          r_hover, r_start, w_next_start;
    logic          w_hit;

    rect_hit #(
        .RECT_X (BTN_X),
        .RECT_Y (BTN_Y),
        .RECT_W (BTN_W),
        .RECT_H (BTN_H)
    ) u_rect_hit (
        .valid  (cursor_valid_in),
        .x      (cursor_x_in),
        .y      (cursor_y_in),
        .hit    (w_hit)
    );

    assign w_dwell_inc = r_dwell + c_dwell_one;
    assign w_miss_inc  = r_miss + MW'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_dwell = r_dwell;
        w_next_miss  = r_miss;
        w_next_start = 1'b0;
        if (!enable_in) begin
            w_next_state = IDLE;
            w_next_dwell = '0;
            w_next_miss  = '0;
        end else if (new_frame_in) begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        w_next_dwell = c_dwell_one;
                        w_next_miss  = '0;
                        if (c_dwell_one == c_dwell_max) begin
                            w_next_start = 1'b1;
                            w_next_state = FIRED;
                        end else begin
                            w_next_state = HOVER;
                        end
                    end
                end
                HOVER, FIRED: begin
                    if (w_hit) begin
                        w_next_miss = '0;
                        if (r_state == HOVER) begin
                            w_next_dwell = w_dwell_inc;
                            if (w_dwell_inc == c_dwell_max) begin
                                w_next_start = 1'b1;
                                w_next_state = FIRED;
                            end
                        end
                    end else if (w_miss_inc == c_miss_max) begin
                        // Cursor has been gone long enough: abandon or re-arm.
                        w_next_state = IDLE;
                        w_next_dwell = '0;
                        w_next_miss  = '0;
                    end else begin
                        w_next_miss = w_miss_inc;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_next_dwell = '0;
                    w_next_miss  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_miss  <= '0;
            r_hover <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dwell <= w_next_dwell;
            r_miss  <= w_next_miss;
            r_hover <= (w_next_state == HOVER);
            r_start <= w_next_start;
        end
    end

    assign hover_out    = r_hover;
    assign progress_out = r_dwell;
    assign start_out    = r_start;

endmodule
`default_nettype wire

// File: tb/tb_start_button_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_start_button_detector
// Brief   : Directed + random bench against a frame-level dwell model
// Revision: 1.0 - initial release
// ============================================================================
module tb_start_button_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        new_frame = 1'b0;
    logic        cursor_valid = 1'b0;
    logic [10:0] cursor_x = '0;
    logic [9:0]  cursor_y = '0;

    logic        hover_a, start_a;
    logic [5:0]  progress_a;
    logic        hover_b, start_b;
    logic [0:0]  progress_b;

    int errors = 0;
    int checks = 0;

    // Model of each instance: mode 0=waiting, 1=dwelling, 2=pressed
    int  ma_mode, ma_dwell, ma_miss;
    bit  ma_fire;
    int  mb_mode, mb_dwell, mb_miss;
    bit  mb_fire;

    always #5 clk = ~clk;

    start_button_detector dut_a (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (enable),
        .new_frame_in    (new_frame),
        .cursor_valid_in (cursor_valid),
        .cursor_x_in     (cursor_x),
        .cursor_y_in     (cursor_y),
        .hover_out       (hover_a),
        .progress_out    (progress_a),
        .start_out       (start_a)
    );

    start_button_detector #(.DWELL_FRAMES(1)) dut_b (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (enable),
        .new_frame_in    (new_frame),
        .cursor_valid_in (cursor_valid),
        .cursor_x_in     (cursor_x),
        .cursor_y_in     (cursor_y),
        .hover_out       (hover_b),
        .progress_out    (progress_b),
        .start_out       (start_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int dmax, input bit hit, inout int mode,
                              inout int dwell, inout int miss, output bit fire);
        fire = 1'b0;
        if (hit) begin
            miss = 0;
            if (mode != 2) begin
                dwell = dwell + 1;
                mode  = 1;
                if (dwell == dmax) begin
                    fire = 1'b1;
                    mode = 2;
                end
            end
        end else if (mode != 0) begin
            miss = miss + 1;
            if (miss == 4) begin
                mode = 0; dwell = 0; miss = 0;
            end
        end
    endtask

    task automatic model_clear();
        ma_mode = 0; ma_dwell = 0; ma_miss = 0; ma_fire = 1'b0;
        mb_mode = 0; mb_dwell = 0; mb_miss = 0; mb_fire = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".hover"},      int'(hover_a),    int'(ma_mode == 1));
        check({tag, ".progress"},   int'(progress_a), ma_dwell);
        check({tag, ".start"},      int'(start_a),    int'(ma_fire));
        check({tag, ".d1.hover"},   int'(hover_b),    0);
        check({tag, ".d1.progress"},int'(progress_b), mb_dwell);
        check({tag, ".d1.start"},   int'(start_b),    int'(mb_fire));
    endtask

    task automatic tick(input string tag, input bit v, input int x, input int y);
        bit hit;
        @(negedge clk);
        cursor_valid = v;
        cursor_x     = 11'(x);
        cursor_y     = 10'(y);
        new_frame    = 1'b1;
        hit = v && (x >= 380) && (x < 580) && (y >= 500) && (y < 600);
        model_step(60, hit, ma_mode, ma_dwell, ma_miss, ma_fire);
        model_step(1,  hit, mb_mode, mb_dwell, mb_miss, mb_fire);
        @(negedge clk);
        new_frame = 1'b0;
        compare_all(tag);
        // Pulse must be gone one cycle later
        @(negedge clk);
        check({tag, ".start_off"},    int'(start_a), 0);
        check({tag, ".d1.start_off"}, int'(start_b), 0);
    endtask

    task automatic abort(input string tag, input bit use_rst);
        @(negedge clk);
        if (use_rst) rst = 1'b1; else enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        model_clear();
        compare_all(tag);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compare_all("reset");

        repeat (60) tick("dwell60", 1'b1, 480, 550);
        check("fired.mode", int'(hover_a), 0);
        repeat (100) tick("hold_inside", 1'b1, 480, 550);
        repeat (4) tick("leave", 1'b1, 10, 10);
        check("leave.progress", int'(progress_a), 0);
        repeat (60) tick("redwell", 1'b1, 480, 550);
        repeat (4) tick("leave2", 1'b0, 480, 550);

        repeat (30) tick("part1", 1'b1, 480, 550);
        repeat (3) tick("gap3", 1'b0, 480, 550);
        repeat (30) tick("part2", 1'b1, 480, 550);
        repeat (4) tick("leave3", 1'b0, 0, 0);
        repeat (30) tick("part1b", 1'b1, 480, 550);
        repeat (4) tick("gap4", 1'b0, 480, 550);

        abort("pre_b0", 1'b0); tick("bnd_tl",   1'b1, 380, 500);
        abort("pre_b1", 1'b0); tick("bnd_br",   1'b1, 579, 599);
        abort("pre_b2", 1'b0); tick("bnd_y600", 1'b1, 579, 600);
        abort("pre_b3", 1'b0); tick("bnd_x580", 1'b1, 580, 550);
        abort("pre_b4", 1'b0); tick("bnd_max",  1'b1, 2047, 1023);
        abort("pre_b5", 1'b0); tick("bnd_x379", 1'b1, 379, 550);

        repeat (50) tick("dwell50a", 1'b1, 480, 550);
        abort("enable_drop", 1'b0);
        repeat (50) tick("dwell50b", 1'b1, 480, 550);
        abort("reset_mid", 1'b1);

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2)
                abort("rnd_abort", r[0]);
            else if (r < 10)
                tick("rnd_far", 1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
            else
                tick("rnd", ($urandom_range(0, 9) != 0),
                     int'($urandom_range(370, 590)), int'($urandom_range(490, 610)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/start_button_detector.md
Name: start_button_detector

Overview:
- Input-side counterpart of the start-screen play button renderer: it decides when the player has "pressed" the on-screen button.
- Once per frame it samples the tracked cursor position and checks it against the play-button rectangle (default x 380..579, y 500..599).
- It counts consecutive dwell frames and emits a one-cycle start pulse after the dwell time elapses.
- It also exports hover and dwell progress so the display path can draw highlight/fill feedback.

Parameters:
- BTN_X, 380, left edge of the button, pixels
- BTN_Y, 500, top edge of the button, pixels
- BTN_W, 200, button width, pixels
- BTN_H, 100, button height, pixels
- DWELL_FRAMES, 60, consecutive hit frames needed to fire (>=1)
- LOST_FRAMES, 4, consecutive miss frames tolerated before dwell is abandoned or re-armed (>=1)

Ports:
- clk_in  input  1  system/pixel clock
- rst_in  input  1  synchronous, active-high reset
- enable_in  input  1  high while the game is in the start screen; low forces IDLE
- new_frame_in  input  1  one-cycle pulse per frame; the only cycle on which the cursor is sampled
- cursor_valid_in  input  1  tracker has a valid cursor this frame
- cursor_x_in  input  11  cursor horizontal position
- cursor_y_in  input  10  cursor vertical position
- hover_out  output  1  cursor is over the button (state HOVER)
- progress_out  output  $clog2(DWELL_FRAMES+1)  current dwell count, 0..DWELL_FRAMES
- start_out  output  1  single-cycle start pulse

Behaviour:
- All outputs are registered.
- Reset (rst_in=1 on a clock edge) values: state=IDLE, dwell=0, miss=0, hover_out=0, progress_out=0, start_out=0. Reset mid-dwell discards all progress.
- Hit definition, combinational on the sampled inputs:
  - cursor_valid_in && x>=BTN_X && x<BTN_X+BTN_W && y>=BTN_Y && y<BTN_Y+BTN_H
  - Compare in 12-bit unsigned so that BTN_X+BTN_W cannot wrap.
- State changes occur only on cycles with new_frame_in=1, except enable_in and rst_in.
- Latency: outputs reflect a frame sample on the cycle after the new_frame_in edge.
- enable_in=0: next state IDLE, dwell=0, miss=0, start_out=0. This takes priority over new_frame_in. Reset takes priority over everything.
- IDLE (on tick):
  - hit and DWELL_FRAMES==1: start_out=1, go FIRED.
  - hit otherwise: dwell=1, miss=0, go HOVER.
  - miss: stay IDLE.
- HOVER (on tick):
  - hit: miss=0, dwell=dwell+1. If the new dwell equals DWELL_FRAMES: start_out=1, go FIRED, and dwell holds at DWELL_FRAMES.
  - miss: miss=miss+1. If miss reaches LOST_FRAMES: dwell=0, miss=0, go IDLE. Otherwise dwell is held (no decay).
- FIRED (on tick), waits for the cursor to leave before re-arming (no auto-repeat):
  - hit: miss=0.
  - miss: miss+1. On reaching LOST_FRAMES: dwell=0, miss=0, go IDLE.
- start_out is high for exactly one clk_in cycle per firing. It is 0 on every other cycle, including all cycles spent in FIRED.
- hover_out=1 iff state==HOVER.
- progress_out=dwell in all states (DWELL_FRAMES while in FIRED).
- new_frame_in held high for several cycles: each high cycle counts as a tick. Upstream guarantees single-cycle pulses; no internal edge detection.

Decomposition:
- Shared package (start_screen_pkg):
  - state enum {IDLE, HOVER, FIRED}
  - play-button geometry constants (380, 500, 200, 100), also used by the renderer so both sides stay consistent
- Sub-module rect_hit (purely combinational point-in-rectangle test), reusable for later menu buttons.
- Dwell/miss counters and the FSM live in the top module.

Test Plan:
- Reset, then 60 ticks with cursor (480,550) valid:
  - progress_out steps 1..60
  - hover_out=1 through tick 59
  - start_out high exactly one cycle after tick 60
  - state FIRED, hover_out=0
- After firing, keep the cursor inside for 100 ticks -> no further start_out. Move it to (10,10) for 4 ticks -> IDLE, progress_out=0. A re-dwell of 60 ticks fires again.
- Dwell 30 ticks, then 3 miss ticks (cursor_valid_in=0), then 30 hit ticks -> progress holds at 30 during the misses and fires on hit tick 60 total. A variant with 4 misses returns to IDLE, progress_out=0.
- Boundary pixels:
  - (380,500) and (579,599) count as hits.
  - (579,600) misses; (580,550) misses.
  - (2047,1023) misses with no wrap.
- Dwell 50 ticks, then drop enable_in for one cycle -> next cycle IDLE, progress_out=0, no start_out. Repeat the scenario with rst_in instead of enable_in: same result.
- Parameter build DWELL_FRAMES=1: the first hit tick from IDLE gives start_out one cycle later and goes to FIRED, with hover_out never asserting.
